// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data memory port between requester A (load/store unit) and
// requester B (debug/DMA). Ties are broken round-robin. Each transaction is
// a grant pulse, then MEM_LAT cycles with the memory port driven, then a
// one-cycle done pulse that carries the read data and the out-of-range flag.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   a_req/a_rw/a_addr/a_wdata  requester A request (rw: 0 = read, 1 = write)
//   b_req/b_rw/b_addr/b_wdata  requester B request
//   a_gnt/b_gnt                one-cycle grant pulses
//   a_done/b_done              one-cycle completion pulses
//   a_rdata/b_rdata            read data, valid with done
//   a_err/b_err                out-of-range flag, valid with done
//   mem_active/mem_rw/mem_index/mem_wdata  memory port, driven only in ACCESS
//   mem_rdata                  memory read data
//   busy                       FSM is not in IDLE
module dmem_arbiter #(
   parameter int MEM_LAT   = 1,
   parameter int MEM_DEPTH = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_rw,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   input  logic        b_req,
   input  logic        b_rw,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        a_gnt,
   output logic        b_gnt,
   output logic        a_done,
   output logic        b_done,
   output logic [31:0] a_rdata,
   output logic [31:0] b_rdata,
   output logic        a_err,
   output logic        b_err,
   output logic        mem_active,
   output logic        mem_rw,
   output logic [31:0] mem_index,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int          EffLat     = (MEM_LAT < 1) ? 1 : MEM_LAT;
   localparam logic [31:0] LatLoad    = 32'(EffLat);
   localparam logic [31:0] DepthLimit = 32'(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

   stateT       state, stateNext;
   logic        lastB, lastBNext;
   logic        ownerB, ownerBNext;
   logic        rwLat, rwLatNext;
   logic [31:0] addrLat, addrLatNext;
   logic [31:0] wdataLat, wdataLatNext;
   logic [31:0] latCount, latCountNext;

   logic        aGntNext, bGntNext, aDoneNext, bDoneNext, aErrNext, bErrNext;
   logic [31:0] aRdataNext, bRdataNext;
   logic        memActiveNext, memRwNext;
   logic [31:0] memIndexNext, memWdataNext;
   logic        winA;
   logic [31:0] captured;

   // State register. lastB resets to 1 so that A wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic. Every output is computed one cycle ahead here and
   // registered below, so a state's outputs appear in the same cycle the
   // FSM occupies that state. The IDLE cycle carrying the grant pulse does
   // not resample requests; it launches the latched transaction instead.
   always_comb begin
      stateNext     = state;
      lastBNext     = lastB;
      ownerBNext    = ownerB;
      rwLatNext     = rwLat;
      addrLatNext   = addrLat;
      wdataLatNext  = wdataLat;
      latCountNext  = latCount;
      aGntNext      = 1'b0;
      bGntNext      = 1'b0;
      aDoneNext     = 1'b0;
      bDoneNext     = 1'b0;
      aErrNext      = 1'b0;
      bErrNext      = 1'b0;
      aRdataNext    = '0;
      bRdataNext    = '0;
      memActiveNext = 1'b0;
      memRwNext     = 1'b0;
      memIndexNext  = '0;
      memWdataNext  = '0;
      winA          = a_req && (!b_req || lastB);
      captured      = rwLat ? 32'd0 : mem_rdata;

      unique case (state)
         IDLE: begin
            if (a_gnt || b_gnt) begin
               if (addrLat >= DepthLimit) begin
                  stateNext = DONE;
                  aDoneNext = !ownerB;
                  bDoneNext = ownerB;
                  aErrNext  = !ownerB;
                  bErrNext  = ownerB;
               end else begin
                  stateNext     = ACCESS;
                  latCountNext  = LatLoad;
                  memActiveNext = 1'b1;
                  memRwNext     = rwLat;
                  memIndexNext  = addrLat;
                  memWdataNext  = wdataLat;
               end
            end else if (a_req || b_req) begin
               aGntNext     = winA;
               bGntNext     = !winA;
               ownerBNext   = !winA;
               lastBNext    = !winA;
               rwLatNext    = winA ? a_rw : b_rw;
               addrLatNext  = winA ? a_addr : b_addr;
               wdataLatNext = winA ? a_wdata : b_wdata;
            end
         end
         ACCESS: begin
            if (latCount <= 32'd1) begin
               stateNext    = DONE;
               latCountNext = '0;
               aDoneNext    = !ownerB;
               bDoneNext    = ownerB;
               aRdataNext   = ownerB ? 32'd0 : captured;
               bRdataNext   = ownerB ? captured : 32'd0;
            end else begin
               latCountNext  = latCount - 32'd1;
               memActiveNext = 1'b1;
               memRwNext     = rwLat;
               memIndexNext  = addrLat;
               memWdataNext  = wdataLat;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Datapath and output registers; reset clears everything mid-transaction
   // so an interrupted access never produces a done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lastB      <= 1'b1;
         ownerB     <= 1'b0;
         rwLat      <= 1'b0;
         addrLat    <= '0;
         wdataLat   <= '0;
         latCount   <= '0;
         a_gnt      <= 1'b0;
         b_gnt      <= 1'b0;
         a_done     <= 1'b0;
         b_done     <= 1'b0;
         a_err      <= 1'b0;
         b_err      <= 1'b0;
         a_rdata    <= '0;
         b_rdata    <= '0;
         mem_active <= 1'b0;
         mem_rw     <= 1'b0;
         mem_index  <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else begin
         lastB      <= lastBNext;
         ownerB     <= ownerBNext;
         rwLat      <= rwLatNext;
         addrLat    <= addrLatNext;
         wdataLat   <= wdataLatNext;
         latCount   <= latCountNext;
         a_gnt      <= aGntNext;
         b_gnt      <= bGntNext;
         a_done     <= aDoneNext;
         b_done     <= bDoneNext;
         a_err      <= aErrNext;
         b_err      <= bErrNext;
         a_rdata    <= aRdataNext;
         b_rdata    <= bRdataNext;
         mem_active <= memActiveNext;
         mem_rw     <= memRwNext;
         mem_index  <= memIndexNext;
         mem_wdata  <= memWdataNext;
         busy       <= (stateNext != IDLE);
      end
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, SHALL set the number of cycles the memory access signals are held per transaction; values below 1 SHALL be treated as 1.
REQ-002 Parameter MEM_DEPTH, default 512, SHALL set the number of valid 32-bit memory words.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_req / b_req  input  1  request from requester A (load/store unit) / B (debug/DMA).
REQ-006 a_rw / b_rw  input  1  0 = read, 1 = write.
REQ-007 a_addr / b_addr  input  32  word index.
REQ-008 a_wdata / b_wdata  input  32  write data.
REQ-009 a_gnt / b_gnt  output  1  one-cycle grant pulse.
REQ-010 a_done / b_done  output  1  one-cycle completion pulse.
REQ-011 a_rdata / b_rdata  output  32  read data, valid while the matching done is high.
REQ-012 a_err / b_err  output  1  out-of-range flag, valid while the matching done is high.
REQ-013 mem_active  output  1  memory enable.
REQ-014 mem_rw  output  1  memory read/write select.
REQ-015 mem_index  output  32  memory word index.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  memory read data.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-020 All outputs SHALL be registered.
REQ-021 Requests SHALL be sampled only in IDLE, and a requester SHALL hold its req until it receives gnt.
REQ-022 In IDLE with a single request, that requester SHALL win.
REQ-023 In IDLE with both requests, the requester not served last SHALL win (round-robin); the last-served pointer SHALL reset to B, so A wins the first tie.
REQ-024 On a win, the arbiter SHALL pulse the winner's gnt for exactly one cycle, latch its rw, addr, wdata and owner, and update the last-served pointer.
REQ-025 If the latched addr is greater than or equal to MEM_DEPTH, the FSM SHALL go directly to DONE with err=1, rdata=0 and no memory access (mem_active stays 0).
REQ-026 Otherwise the FSM SHALL enter ACCESS and load the latency counter with MEM_LAT.
REQ-027 In ACCESS, mem_active SHALL be 1, and mem_rw, mem_index and mem_wdata SHALL hold the latched values stable.
REQ-028 The latency counter SHALL decrement once per cycle in ACCESS.
REQ-029 When the counter reaches 1, the arbiter SHALL capture mem_rdata (reads only) and transition to DONE.
REQ-030 Outside ACCESS, mem_active, mem_rw, mem_index and mem_wdata SHALL all be 0.
REQ-031 In DONE, the owner's done SHALL be high for exactly one cycle; rdata SHALL carry the captured word for reads and 0 for writes, err SHALL be 0 for in-range accesses, and the FSM SHALL return to IDLE.
REQ-032 Outside DONE, the owner's rdata and err SHALL be 0, and the non-owner's done, rdata and err SHALL always be 0.
REQ-033 Transaction timing SHALL be: gnt in cycle t, ACCESS in cycles t+1..t+MEM_LAT, done in cycle t+MEM_LAT+1, next gnt no earlier than t+MEM_LAT+2.
REQ-034 Deasserting req after gnt SHALL NOT abort the transaction.
REQ-035 A request arriving during ACCESS or DONE SHALL wait until IDLE.
REQ-036 gnt and done SHALL never be high for both requesters in the same cycle.

Reset
REQ-037 Asserting reset at any time, including mid-transaction, SHALL immediately force IDLE, reset the last-served pointer to B, clear the counter, and drive every output to 0.
REQ-038 A transaction interrupted by reset SHALL produce no done pulse and SHALL NOT be resumed.

Verification
REQ-039 A read, addr=5, with memory word 5 = 0xDEADBEEF and MEM_LAT=1 -> a_gnt at t, mem_active=1 with mem_index=5 at t+1, a_done=1 with a_rdata=0xDEADBEEF at t+2.
REQ-040 A and B request simultaneously, both held for three transactions -> grant order A, B, A, and b_done never overlaps a_done.
REQ-041 B write, addr=600, wdata=0x1 -> mem_active stays 0, and b_done=1 with b_err=1 one cycle after b_gnt.
REQ-042 MEM_LAT=3, A write, addr=10, wdata=0x55 -> mem_active high for exactly 3 cycles with stable index 10 and data 0x55, then a_done with a_rdata=0.
REQ-043 reset asserted during ACCESS -> outputs go to 0 asynchronously, no done pulse, and the next tie after reset is granted to A.
REQ-044 A request pulled low the cycle after a_gnt -> the transaction still completes and a_done is asserted.
